// File: rtl/niosii_debug_scan_master_if.sv
// Command/response handshake and virtual-JTAG signal bundle between a scan
// initiator (master) and the command source / debug-module side (slave).
interface niosii_debug_scan_master_if #(
    parameter int unsigned DR_WIDTH = 38,
    parameter int unsigned IR_WIDTH = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_dr;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_dr;
    logic [IR_WIDTH-1:0] rsp_ir_out;

    logic                vji_tck;
    logic                vji_tdi;
    logic                vji_tdo;
    logic [IR_WIDTH-1:0] vji_ir_in;
    logic [IR_WIDTH-1:0] vji_ir_out;
    logic                vji_rti;
    logic                vji_uir;
    logic                vji_cdr;
    logic                vji_sdr;
    logic                vji_udr;

    modport master (
        input  cmd_valid, cmd_ir, cmd_dr, rsp_ready, vji_tdo, vji_ir_out,
        output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out,
               vji_tck, vji_tdi, vji_ir_in, vji_rti,
               vji_uir, vji_cdr, vji_sdr, vji_udr
    );

    modport slave (
        output cmd_valid, cmd_ir, cmd_dr, rsp_ready, vji_tdo, vji_ir_out,
        input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out,
               vji_tck, vji_tdi, vji_ir_in, vji_rti,
               vji_uir, vji_cdr, vji_sdr, vji_udr
    );
endinterface

// File: rtl/niosii_debug_scan_master.sv
// On-chip virtual-JTAG initiator: runs one UIR/CDR/SDR/UDR sequence per
// accepted command at a divided tck and returns the captured scan-out.
module niosii_debug_scan_master #(
    parameter int unsigned DR_WIDTH = 38,
    parameter int unsigned IR_WIDTH = 2,
    parameter int unsigned TCK_DIV  = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    niosii_debug_scan_master_if.master bus
);
    localparam int unsigned     BW       = $clog2(DR_WIDTH);
    localparam logic [7:0]      DIV_LAST = 8'(TCK_DIV - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_UIR, S_CDR, S_SDR, S_UDR, S_RESP
    } state_e;

    state_e              state_q;
    logic [7:0]          div_cnt_q;
    logic [BW-1:0]       bit_q;
    logic [DR_WIDTH-1:0] tx_q;
    logic [DR_WIDTH-1:0] rx_q;
    logic [DR_WIDTH-1:0] rsp_dr_q;
    logic [IR_WIDTH-1:0] ir_in_q;
    logic [IR_WIDTH-1:0] rsp_ir_q;
    logic                tck_q, tdi_q, rti_q;
    logic                uir_q, cdr_q, sdr_q, udr_q;
    logic                cmd_ready_q, rsp_valid_q;
    logic                half_done;

    assign half_done = (div_cnt_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            div_cnt_q   <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rsp_dr_q    <= '0;
            ir_in_q     <= '0;
            rsp_ir_q    <= '0;
            tck_q       <= 1'b0;
            tdi_q       <= 1'b0;
            rti_q       <= 1'b1;
            uir_q       <= 1'b0;
            cdr_q       <= 1'b0;
            sdr_q       <= 1'b0;
            udr_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    rti_q       <= 1'b1;
                    cmd_ready_q <= 1'b1;
                    if (bus.cmd_valid && cmd_ready_q) begin
                        ir_in_q     <= bus.cmd_ir;
                        tx_q        <= bus.cmd_dr;
                        cmd_ready_q <= 1'b0;
                        rti_q       <= 1'b0;
                        state_q     <= S_LOAD;
                    end
                end
                // One settle cycle after accept so the first tck period starts cleanly.
                S_LOAD: begin
                    uir_q     <= 1'b1;
                    tck_q     <= 1'b0;
                    div_cnt_q <= '0;
                    state_q   <= S_UIR;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rti_q       <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    if (!half_done) begin
                        div_cnt_q <= div_cnt_q + 8'd1;
                    end else begin
                        div_cnt_q <= '0;
                        tck_q     <= ~tck_q;
                        if (!tck_q) begin
                            if (state_q == S_UIR) rsp_ir_q <= bus.vji_ir_out;
                            if (state_q == S_SDR) rx_q <= {bus.vji_tdo, rx_q[DR_WIDTH-1:1]};
                        end else if (state_q == S_UIR) begin
                            uir_q   <= 1'b0;
                            cdr_q   <= 1'b1;
                            state_q <= S_CDR;
                        end else if (state_q == S_CDR) begin
                            cdr_q   <= 1'b0;
                            sdr_q   <= 1'b1;
                            tdi_q   <= tx_q[0];
                            bit_q   <= '0;
                            state_q <= S_SDR;
                        end else if (state_q == S_SDR) begin
                            // tx_q shifts right each period so the next bit is always tx_q[1].
                            if (bit_q == BIT_LAST) begin
                                sdr_q   <= 1'b0;
                                udr_q   <= 1'b1;
                                tdi_q   <= 1'b0;
                                state_q <= S_UDR;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                                tx_q  <= tx_q >> 1;
                                tdi_q <= tx_q[1];
                            end
                        end else begin
                            udr_q       <= 1'b0;
                            rsp_dr_q    <= rx_q;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_dr     = rsp_dr_q;
    assign bus.rsp_ir_out = rsp_ir_q;
    assign bus.vji_tck    = tck_q;
    assign bus.vji_tdi    = tdi_q;
    assign bus.vji_ir_in  = ir_in_q;
    assign bus.vji_rti    = rti_q;
    assign bus.vji_uir    = uir_q;
    assign bus.vji_cdr    = cdr_q;
    assign bus.vji_sdr    = sdr_q;
    assign bus.vji_udr    = udr_q;
endmodule

// File: tb/tb_niosii_debug_scan_master.sv
// Bench for the debug scan master: two instances (TCK_DIV 4 and 1) checked every
// cycle against a timeline model of the scan, plus literal checks of key results.
module tb_niosii_debug_scan_master;
    localparam int DR    = 38;
    localparam int IR    = 2;
    localparam int DIV_A = 4;
    localparam int DIV_B = 1;

    localparam int M_RDY  = 0;
    localparam int M_NRDY = 1;
    localparam int M_BUSY = 2;
    localparam int M_RESP = 3;

    typedef struct packed {
        logic          cmd_ready;
        logic          rsp_valid;
        logic [DR-1:0] rsp_dr;
        logic [IR-1:0] rsp_ir_out;
        logic          tck;
        logic          tdi;
        logic [IR-1:0] ir_in;
        logic          rti;
        logic          uir;
        logic          cdr;
        logic          sdr;
        logic          udr;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn [2];
    logic          cv   [2];
    logic [IR-1:0] cir  [2];
    logic [DR-1:0] cdr  [2];
    logic          rr   [2];
    logic [IR-1:0] iro  [2];
    logic          tdo_r[2];
    obs_t          obs  [2];

    niosii_debug_scan_master_if #(.DR_WIDTH(DR), .IR_WIDTH(IR)) bus_a ();
    niosii_debug_scan_master_if #(.DR_WIDTH(DR), .IR_WIDTH(IR)) bus_b ();

    assign bus_a.cmd_valid  = cv[0];
    assign bus_a.cmd_ir     = cir[0];
    assign bus_a.cmd_dr     = cdr[0];
    assign bus_a.rsp_ready  = rr[0];
    assign bus_a.vji_tdo    = tdo_r[0];
    assign bus_a.vji_ir_out = iro[0];
    assign bus_b.cmd_valid  = cv[1];
    assign bus_b.cmd_ir     = cir[1];
    assign bus_b.cmd_dr     = cdr[1];
    assign bus_b.rsp_ready  = rr[1];
    assign bus_b.vji_tdo    = tdo_r[1];
    assign bus_b.vji_ir_out = iro[1];

    assign obs[0] = {bus_a.cmd_ready, bus_a.rsp_valid, bus_a.rsp_dr, bus_a.rsp_ir_out,
                     bus_a.vji_tck, bus_a.vji_tdi, bus_a.vji_ir_in, bus_a.vji_rti,
                     bus_a.vji_uir, bus_a.vji_cdr, bus_a.vji_sdr, bus_a.vji_udr};
    assign obs[1] = {bus_b.cmd_ready, bus_b.rsp_valid, bus_b.rsp_dr, bus_b.rsp_ir_out,
                     bus_b.vji_tck, bus_b.vji_tdi, bus_b.vji_ir_in, bus_b.vji_rti,
                     bus_b.vji_uir, bus_b.vji_cdr, bus_b.vji_sdr, bus_b.vji_udr};

    niosii_debug_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(IR), .TCK_DIV(DIV_A)) dut_a (
        .clk(clk), .reset_n(rstn[0]), .bus(bus_a));
    niosii_debug_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(IR), .TCK_DIV(DIV_B)) dut_b (
        .clk(clk), .reset_n(rstn[1]), .bus(bus_b));

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit armed       = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s timeout waiting for DUT", name);
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? DIV_A : DIV_B;
    endfunction

    // ---------------- behavioural model: scan expressed as a timeline ----------------
    int            mmode  [2];
    int            mk     [2];
    int            macc   [2];
    logic [DR-1:0] mdr    [2];
    logic [DR-1:0] mres   [2];
    logic [DR-1:0] mrsp_dr[2];
    logic [IR-1:0] mir_in [2];
    logic [IR-1:0] mrsp_ir[2];
    logic [DR-1:0] tgt_data[2];
    logic          tgt_lb  [2];

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (!rstn[i]) begin
                mmode[i]   = M_RDY;
                mk[i]      = 0;
                mir_in[i]  = '0;
                mrsp_ir[i] = '0;
                mrsp_dr[i] = '0;
            end else begin
                case (mmode[i])
                    M_RDY: if (cv[i]) begin
                        mmode[i]  = M_BUSY;
                        mk[i]     = 0;
                        macc[i]   = cyc;
                        mdr[i]    = cdr[i];
                        mir_in[i] = cir[i];
                        mres[i]   = tgt_lb[i] ? {cdr[i][DR-2:0], 1'b0} : tgt_data[i];
                    end
                    M_NRDY: mmode[i] = M_RDY;
                    M_BUSY: begin
                        mk[i] = mk[i] + 1;
                        if (mk[i] == 1 + div_of(i)) mrsp_ir[i] = iro[i];
                        if (mk[i] == 1 + 2 * (DR + 3) * div_of(i)) begin
                            mmode[i]   = M_RESP;
                            mrsp_dr[i] = mres[i];
                        end
                    end
                    default: if (rr[i]) mmode[i] = M_NRDY;
                endcase
            end
        end
    end

    function automatic obs_t expect_obs(input int i);
        obs_t e;
        int d, off, p, ph;
        d            = div_of(i);
        e            = '0;
        e.rsp_dr     = mrsp_dr[i];
        e.rsp_ir_out = mrsp_ir[i];
        e.ir_in      = mir_in[i];
        case (mmode[i])
            M_RDY:  begin e.cmd_ready = 1'b1; e.rti = 1'b1; end
            M_NRDY: e.rti = 1'b1;
            M_RESP: e.rsp_valid = 1'b1;
            default: if (mk[i] >= 1) begin
                off   = mk[i] - 1;
                p     = off / (2 * d);
                ph    = off % (2 * d);
                e.tck = (ph >= d);
                e.uir = (p == 0);
                e.cdr = (p == 1);
                e.sdr = (p >= 2) && (p <= DR + 1);
                e.udr = (p == DR + 2);
                if (e.sdr) e.tdi = mdr[i][p-2];
            end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++)
                check($sformatf("cyc%0d_dut%0d", cyc, i), 64'(obs[i]), 64'(expect_obs(i)));
        end
    end

    // ---------------- target model: fixed word or one-period loopback ----------------
    int   tidx   [2];
    logic tp_sdr [2];
    logic tp_tck [2];
    logic lb_last[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (obs[i].sdr && !tp_sdr[i]) begin
                tidx[i]  = 0;
                tdo_r[i] = tgt_lb[i] ? 1'b0 : tgt_data[i][0];
            end else if (obs[i].sdr && tp_tck[i] && !obs[i].tck) begin
                tidx[i]  = tidx[i] + 1;
                tdo_r[i] = tgt_lb[i] ? lb_last[i] : ((tidx[i] < DR) ? tgt_data[i][tidx[i]] : 1'b0);
            end
            if (obs[i].sdr && obs[i].tck) lb_last[i] = obs[i].tdi;
            tp_sdr[i] = obs[i].sdr;
            tp_tck[i] = obs[i].tck;
        end
    end

    int   n_rise[2];
    int   n_sdr [2];
    int   n_tdi1[2];
    logic rc_prev[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (obs[i].tck && !rc_prev[i]) begin
                n_rise[i] = n_rise[i] + 1;
                if (obs[i].sdr) n_sdr[i] = n_sdr[i] + 1;
                if (obs[i].sdr && obs[i].tdi) n_tdi1[i] = n_tdi1[i] + 1;
            end
            rc_prev[i] = obs[i].tck;
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_scan(input int i, input logic [IR-1:0] ir, input logic [DR-1:0] dr,
                              input logic lb, input logic [DR-1:0] td, input logic [IR-1:0] irout,
                              output bit ok);
        int n;
        @(negedge clk);
        tgt_lb[i] = lb; tgt_data[i] = td; iro[i] = irout;
        cir[i] = ir; cdr[i] = dr; cv[i] = 1'b1; rr[i] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (mmode[i] != M_BUSY && n < 50);
        ok = (mmode[i] == M_BUSY);
        if (!ok) timeout("accept");
        cv[i] = 1'b0; cir[i] = ~ir; cdr[i] = ~dr;
    endtask

    task automatic finish_scan(input int i, input int hold, input bit noise, output int lat,
                               output logic [DR-1:0] got_dr, output logic [IR-1:0] got_ir,
                               output logic [IR-1:0] got_irin);
        int n;
        lat = -1; got_dr = '0; got_ir = '0; got_irin = '0;
        n = 0;
        while (!obs[i].rsp_valid && n < 3000) begin
            @(negedge clk); n++;
            if (noise) begin
                cv[i]  = 1'($urandom_range(0, 1));
                cdr[i] = DR'({$urandom, $urandom});
            end
        end
        if (!obs[i].rsp_valid) begin
            timeout("rsp_valid");
            cv[i] = 1'b0;
        end else begin
            lat      = cyc - macc[i];
            got_dr   = obs[i].rsp_dr;
            got_ir   = obs[i].rsp_ir_out;
            got_irin = obs[i].ir_in;
            repeat (hold) begin
                @(negedge clk);
                if (noise) cv[i] = 1'($urandom_range(0, 1));
            end
            cv[i] = 1'b0; rr[i] = 1'b1;
            @(negedge clk);
            rr[i] = 1'b0;
        end
    endtask

    task automatic clear_counts(input int i);
        n_rise[i] = 0; n_sdr[i] = 0; n_tdi1[i] = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            ok;
        int            lat, n_rv;
        logic [DR-1:0] got_dr, dr, td;
        logic [IR-1:0] got_ir, got_irin, ir, irout;
        logic          lb;

        for (int i = 0; i < 2; i++) begin
            rstn[i] = 1'b0; cv[i] = 1'b0; cir[i] = '0; cdr[i] = '0; rr[i] = 1'b0;
            iro[i] = '0; tdo_r[i] = 1'b0; tgt_data[i] = '0; tgt_lb[i] = 1'b0;
            tp_sdr[i] = 1'b0; tp_tck[i] = 1'b0; lb_last[i] = 1'b0; tidx[i] = 0;
            rc_prev[i] = 1'b0; n_rise[i] = 0; n_sdr[i] = 0; n_tdi1[i] = 0;
        end
        @(negedge clk);
        armed = 1'b1;
        repeat (2) @(negedge clk);
        rstn[0] = 1'b1; rstn[1] = 1'b1;

        repeat (100) @(negedge clk);
        check("idle_after_reset", 64'({obs[0].cmd_ready, obs[0].rti, obs[0].tck, obs[0].uir,
              obs[0].cdr, obs[0].sdr, obs[0].udr, obs[0].rsp_valid}), 64'(8'b1100_0000));

        // Loopback: result is the command shifted up by one with a 0 entering the LSB.
        clear_counts(0);
        start_scan(0, 2'b01, 38'h2A_5A5A_5A5A, 1'b1, '0, 2'b11, ok);
        if (ok) begin
            finish_scan(0, 0, 1'b0, lat, got_dr, got_ir, got_irin);
            check("lb_latency", 64'(lat), 64'(329));
            check("lb_rsp_dr", 64'(got_dr), 64'(38'h14_B4B4_B4B4));
            check("lb_tck_rises", 64'(n_rise[0]), 64'(41));
            check("lb_sdr_rises", 64'(n_sdr[0]), 64'(38));
        end

        // Fixed target word, response stalled for 50 cycles with cmd_valid noise.
        start_scan(0, 2'b01, 38'h01_2345_6789, 1'b0, 38'h3F_DEAD_BEEF, 2'b10, ok);
        if (ok) begin
            finish_scan(0, 50, 1'b1, lat, got_dr, got_ir, got_irin);
            check("tgt_rsp_dr", 64'(got_dr), 64'(38'h3F_DEAD_BEEF));
            check("tgt_rsp_ir", 64'(got_ir), 64'(2'b10));
            check("tgt_ir_in", 64'(got_irin), 64'(2'b01));
            check("release_gap", 64'({obs[0].rsp_valid, obs[0].cmd_ready}), 64'(2'b00));
            @(negedge clk);
            check("release_ready", 64'({obs[0].rsp_valid, obs[0].cmd_ready}), 64'(2'b01));
        end

        // Reset in the middle of SDR bit 17 (tck high phase).
        start_scan(0, 2'b11, 38'h15_5555_5555, 1'b0, 38'h0A_AAAA_AAAA, 2'b01, ok);
        if (ok) begin
            repeat (1 + (2 + 17) * 2 * DIV_A + DIV_A) @(negedge clk);
            rstn[0] = 1'b0;
            @(negedge clk);
            check("midreset_outputs", 64'({obs[0].tck, obs[0].sdr, obs[0].cmd_ready, obs[0].rsp_valid}),
                  64'(4'b0010));
            rstn[0] = 1'b1;
            n_rv = 0;
            repeat (400) begin
                @(negedge clk);
                if (obs[0].rsp_valid) n_rv++;
            end
            check("midreset_no_rsp", 64'(n_rv), 64'(0));
        end
        td = DR'({$urandom, $urandom});
        start_scan(0, 2'b10, DR'({$urandom, $urandom}), 1'b0, td, 2'b01, ok);
        if (ok) begin
            finish_scan(0, 3, 1'b0, lat, got_dr, got_ir, got_irin);
            check("post_reset_rsp_dr", 64'(got_dr), 64'(td));
            check("post_reset_rsp_ir", 64'(got_ir), 64'(2'b01));
        end

        // TCK_DIV = 1 instance, all-ones data.
        clear_counts(1);
        td = DR'({$urandom, $urandom});
        start_scan(1, 2'b01, '1, 1'b0, td, 2'b11, ok);
        if (ok) begin
            finish_scan(1, 0, 1'b0, lat, got_dr, got_ir, got_irin);
            check("div1_latency", 64'(lat), 64'(83));
            check("div1_tck_rises", 64'(n_rise[1]), 64'(41));
            check("div1_tdi_ones", 64'(n_tdi1[1]), 64'(38));
            check("div1_rsp_dr", 64'(got_dr), 64'(td));
            check("div1_rsp_ir", 64'(got_ir), 64'(2'b11));
        end

        // Randomised scans on both instances.
        for (int t = 0; t < 14; t++) begin
            int i;
            i     = (t % 3 == 2) ? 1 : 0;
            ir    = IR'($urandom);
            dr    = DR'({$urandom, $urandom});
            td    = DR'({$urandom, $urandom});
            lb    = 1'($urandom_range(0, 1));
            irout = IR'($urandom);
            start_scan(i, ir, dr, lb, td, irout, ok);
            if (ok) begin
                finish_scan(i, int'($urandom_range(0, 20)), 1'b1, lat, got_dr, got_ir, got_irin);
                check($sformatf("rnd%0d_latency", t), 64'(lat), 64'(1 + 2 * (DR + 3) * div_of(i)));
                check($sformatf("rnd%0d_rsp_dr", t), 64'(got_dr), 64'(lb ? {dr[DR-2:0], 1'b0} : td));
                check($sformatf("rnd%0d_rsp_ir", t), 64'(got_ir), 64'(irout));
                check($sformatf("rnd%0d_ir_in", t), 64'(got_irin), 64'(ir));
            end
            repeat (int'($urandom_range(1, 5))) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/niosii_debug_scan_master.md
Name: niosii_debug_scan_master

Overview:
- On-chip initiator for the Nios II JTAG debug module's virtual-JTAG slave port.
- Generates the virtual JTAG signals the debug module expects (tck, tdi, ir_in, uir/cdr/sdr/udr, rti) from a clk-domain command interface, and returns the captured 38-bit scan-out.
- Lets on-chip logic issue debug scans (break/ocimem/trace commands) without an external JTAG cable; sits between a command source and the debug module's tck-side logic.

Parameters:
- DR_WIDTH, 38, data-register scan length in bits.
- IR_WIDTH, 2, virtual instruction register width.
- TCK_DIV, 4, clk cycles per tck half-period; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  scan request.
- cmd_ready  out  1  master idle and able to accept a request.
- cmd_ir  in  IR_WIDTH  virtual IR value for the scan.
- cmd_dr  in  DR_WIDTH  data shifted to the target, LSB first.
- rsp_valid  out  1  scan complete, result held.
- rsp_ready  in  1  result consumed.
- rsp_dr  out  DR_WIDTH  data shifted out of the target.
- rsp_ir_out  out  IR_WIDTH  target ir_out, sampled during UIR.
- vji_tck  out  1  generated test clock (registered).
- vji_tdi  out  1  serial data to the target.
- vji_tdo  in  1  serial data from the target.
- vji_ir_in  out  IR_WIDTH  virtual IR value driven to the target.
- vji_ir_out  in  IR_WIDTH  target IR status.
- vji_rti  out  1  run-test-idle indication.
- vji_uir, vji_cdr, vji_sdr, vji_udr  out  1 each  virtual state strobes.

Behaviour:
- Reset (reset_n = 0 at a clk edge) forces every output to its reset value: all outputs 0 except vji_rti = 1 and cmd_ready = 1. State goes to IDLE and the half-period counter clears.
- tck period: 2*TCK_DIV clk cycles, TCK_DIV with tck low then TCK_DIV with tck high.
  - Each period starts with its low phase.
  - Strobes, vji_tdi and vji_ir_in change only on the clk edge that begins a low phase.
  - A "rising sample" is the clk edge on which vji_tck goes 0->1; inputs are sampled there.
- States and periods per state: IDLE, UIR (1 tck period), CDR (1), SDR (DR_WIDTH), UDR (1), RESP.
- IDLE:
  - vji_rti = 1, cmd_ready = 1, tck held 0.
  - When cmd_valid and cmd_ready: latch cmd_ir into vji_ir_in and cmd_dr into the tx shift register, drop cmd_ready, and go to UIR on the next edge.
- UIR: vji_uir = 1 for the whole period; vji_ir_out is captured into rsp_ir_out at the rising sample.
- CDR: vji_cdr = 1 for the whole period.
- SDR: vji_sdr = 1.
  - Period i (0..DR_WIDTH-1) drives tx bit i on vji_tdi.
  - At each rising sample the rx register becomes {vji_tdo, rx[DR_WIDTH-1:1]}.
  - After DR_WIDTH periods, rx holds the target bits in transmit order (first bit in LSB).
- UDR: vji_udr = 1 for one period, then rx is copied to rsp_dr.
- RESP:
  - rsp_valid = 1; rsp_dr and rsp_ir_out stay stable while rsp_valid && !rsp_ready.
  - On rsp_ready, return to IDLE; rsp_valid drops the same edge.
  - cmd_ready reasserts the cycle after rsp_valid drops; there is no back-to-back overlap.
- Latency: rsp_valid rises exactly 1 + (DR_WIDTH+3)*2*TCK_DIV clk cycles after the accept edge. Defaults give 329.
- Exactly one of uir/cdr/sdr/udr is high outside IDLE and RESP; all are low in IDLE and RESP.
- vji_tck and vji_rti are 0 in RESP.
- vji_ir_in holds its value through RESP and IDLE until the next accept.
- cmd_valid is ignored while cmd_ready = 0; cmd_ir and cmd_dr changes after accept have no effect.
- Reset mid-scan:
  - Aborts on the reset edge with no partial response.
  - tck goes 0 on that edge, with no glitch high.
- TCK_DIV = 1 gives tck = clk/2 and must work identically.

Test Plan:
- After reset, with no command: cmd_ready = 1, vji_rti = 1, vji_tck = 0, all strobes = 0, rsp_valid = 0, and these hold for 100 cycles.
- Loopback (vji_tdo = vji_tdi delayed one tck period, first bit 0), cmd_ir = 2'b01, cmd_dr = 38'h2A_5A5A_5A5A, TCK_DIV = 4 -> rsp_valid at exactly cycle 329 after accept, rsp_dr = cmd_dr shifted by one; exactly 41 tck rising edges, of which 38 have vji_sdr = 1.
- Target model returning 38'h3F_DEAD_BEEF on vji_tdo LSB first, vji_ir_out = 2'b10 -> rsp_dr = 38'h3F_DEAD_BEEF, rsp_ir_out = 2'b10, vji_ir_in = 2'b01 throughout.
- Hold rsp_ready = 0 for 50 cycles -> rsp_valid and rsp_dr stable, cmd_ready = 0, and a new cmd_valid is not accepted; rsp_ready = 1 -> IDLE next edge.
- reset_n = 0 for one cycle at SDR bit 17 -> vji_tck = 0, vji_sdr = 0 and cmd_ready = 1 after that edge; no rsp_valid; the next command completes normally.
- TCK_DIV = 1, all-ones cmd_dr -> tck toggles every clk, rsp_valid at cycle 83, vji_tdi = 1 for all 38 SDR periods.
